// File: rtl/aes_vector_player_if.sv
// Connection between the vector player and the AES core it drives.
// The player is the master: it drives enable/data/key and takes back the result.
interface aes_vector_player_if #(
  parameter int unsigned DATA_W = 128
) ();
  logic              aes_en;
  logic [DATA_W-1:0] aes_data_in;
  logic [DATA_W-1:0] aes_key_in;
  logic [DATA_W-1:0] aes_data_out;
  logic              aes_data_out_valid;

  modport master (
    output aes_en, aes_data_in, aes_key_in,
    input  aes_data_out, aes_data_out_valid
  );

  modport slave (
    input  aes_en, aes_data_in, aes_key_in,
    output aes_data_out, aes_data_out_valid
  );
endinterface

// File: rtl/aes_vector_player.sv
// Plays a table of {plaintext, key, expected} vectors into an AES core and scores the results
// with saturating pass/fail/timeout/spurious counters and a first-failure capture.
module aes_vector_player #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              AES_clk,
  input  logic              AES_rst_n,
  input  logic              cfg_wr_en,
  input  logic [AW-1:0]     cfg_wr_addr,
  input  logic [1:0]        cfg_wr_sel,
  input  logic [DATA_W-1:0] cfg_wr_data,
  input  logic [AW:0]       cfg_num,
  input  logic              start,
  input  logic              abort,
  aes_vector_player_if.master aes,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  timeout_cnt,
  output logic [CNT_W-1:0]  spurious_cnt,
  output logic              first_fail_vld,
  output logic [AW-1:0]     first_fail_idx,
  output logic [DATA_W-1:0] first_fail_data
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [DATA_W-1:0] pt_mem  [DEPTH];
  logic [DATA_W-1:0] key_mem [DEPTH];
  logic [DATA_W-1:0] exp_mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW:0]       num_q, num_d;
  logic [TW-1:0]     cyc_q, cyc_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] din_q, din_d, key_q, key_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d, spur_q, spur_d;
  logic              ff_vld_q, ff_vld_d;
  logic [AW-1:0]     ff_idx_q, ff_idx_d;
  logic [DATA_W-1:0] ff_data_q, ff_data_d;

  logic [AW:0]       num_clamped;
  logic [AW:0]       nxt_slot;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Table fields are plain storage; host writes are only accepted while idle.
  always_ff @(posedge AES_clk) begin
    if (cfg_wr_en && !busy_q) begin
      case (cfg_wr_sel)
        2'd0:    pt_mem[cfg_wr_addr]  <= cfg_wr_data;
        2'd1:    key_mem[cfg_wr_addr] <= cfg_wr_data;
        2'd2:    exp_mem[cfg_wr_addr] <= cfg_wr_data;
        default: ;
      endcase
    end
  end

  assign num_clamped = (cfg_num > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_num;
  assign nxt_slot    = {1'b0, idx_q} + (AW+1)'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    cyc_d     = cyc_q;
    gap_d     = gap_q;
    en_d      = en_q;
    din_d     = din_q;
    key_d     = key_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    tmo_d     = tmo_q;
    spur_d    = spur_q;
    ff_vld_d  = ff_vld_q;
    ff_idx_d  = ff_idx_q;
    ff_data_d = ff_data_q;

    if (state_q != StRun && aes.aes_data_out_valid) spur_d = sat_inc(spur_q);

    if (abort) begin
      state_d = StIdle;
      en_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            pass_d   = '0;
            fail_d   = '0;
            tmo_d    = '0;
            spur_d   = '0;
            ff_vld_d = 1'b0;
            ff_idx_d = '0;
            ff_data_d = '0;
            idx_d    = '0;
            cyc_d    = '0;
            num_d    = num_clamped;
            din_d    = pt_mem[0];
            key_d    = key_mem[0];
            if (num_clamped == '0) begin
              state_d = StDone;
            end else begin
              state_d = StRun;
              en_d    = 1'b1;
            end
          end
        end
        StRun: begin
          // A result arriving on the last timeout cycle still counts as a compare.
          if (aes.aes_data_out_valid) begin
            if (aes.aes_data_out == exp_mem[idx_q]) begin
              pass_d = sat_inc(pass_q);
            end else begin
              fail_d = sat_inc(fail_q);
              if (!ff_vld_q) begin
                ff_vld_d  = 1'b1;
                ff_idx_d  = idx_q;
                ff_data_d = aes.aes_data_out;
              end
            end
            state_d = StGap;
            en_d    = 1'b0;
            gap_d   = '0;
          end else if (cyc_q == TW'(TIMEOUT - 1)) begin
            tmo_d  = sat_inc(tmo_q);
            fail_d = sat_inc(fail_q);
            if (!ff_vld_q) begin
              ff_vld_d  = 1'b1;
              ff_idx_d  = idx_q;
              ff_data_d = '0;
            end
            state_d = StGap;
            en_d    = 1'b0;
            gap_d   = '0;
          end else begin
            cyc_d = cyc_q + TW'(1);
          end
        end
        StGap: begin
          if (gap_q == GW'(GAP_CYC - 1)) begin
            if (nxt_slot < num_q) begin
              idx_d   = nxt_slot[AW-1:0];
              din_d   = pt_mem[nxt_slot[AW-1:0]];
              key_d   = key_mem[nxt_slot[AW-1:0]];
              cyc_d   = '0;
              en_d    = 1'b1;
              state_d = StRun;
            end else begin
              state_d = StDone;
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      num_q     <= '0;
      cyc_q     <= '0;
      gap_q     <= '0;
      en_q      <= 1'b0;
      din_q     <= '0;
      key_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= '0;
      fail_q    <= '0;
      tmo_q     <= '0;
      spur_q    <= '0;
      ff_vld_q  <= 1'b0;
      ff_idx_q  <= '0;
      ff_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      cyc_q     <= cyc_d;
      gap_q     <= gap_d;
      en_q      <= en_d;
      din_q     <= din_d;
      key_q     <= key_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      tmo_q     <= tmo_d;
      spur_q    <= spur_d;
      ff_vld_q  <= ff_vld_d;
      ff_idx_q  <= ff_idx_d;
      ff_data_q <= ff_data_d;
    end
  end

  assign aes.aes_en      = en_q;
  assign aes.aes_data_in = din_q;
  assign aes.aes_key_in  = key_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass_cnt        = pass_q;
  assign fail_cnt        = fail_q;
  assign timeout_cnt     = tmo_q;
  assign spurious_cnt    = spur_q;
  assign first_fail_vld  = ff_vld_q;
  assign first_fail_idx  = ff_idx_q;
  assign first_fail_data = ff_data_q;

endmodule

// File: tb/tb_aes_vector_player.sv
// Randomized bench for aes_vector_player: a stand-in AES core answers with a fixed function,
// and a table-level model predicts every counter and the first-failure capture.
module tb_aes_vector_player;
  localparam int DW = 128, DEPTH = 8, TIMEOUT = 64, AW = 3;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cfg_wr_en = 1'b0;
  logic [AW-1:0] cfg_wr_addr = '0;
  logic [1:0]    cfg_wr_sel = '0;
  logic [DW-1:0] cfg_wr_data = '0;
  logic [AW:0]   cfg_num = '0;
  logic          start = 1'b0, abort = 1'b0;
  logic          busy, done, ff_vld;
  logic [7:0]    pass_cnt, fail_cnt, timeout_cnt, spurious_cnt;
  logic [AW-1:0] ff_idx;
  logic [DW-1:0] ff_data;

  aes_vector_player_if #(.DATA_W(DW)) bus ();

  logic          rsp_valid = 1'b0, inj_valid = 1'b0;
  logic [DW-1:0] rsp_data = '0;
  assign bus.aes_data_out_valid = rsp_valid | inj_valid;
  assign bus.aes_data_out       = rsp_data;

  aes_vector_player dut (
    .AES_clk(clk), .AES_rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_sel(cfg_wr_sel),
    .cfg_wr_data(cfg_wr_data), .cfg_num(cfg_num), .start(start), .abort(abort),
    .aes(bus), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt),
    .spurious_cnt(spurious_cnt), .first_fail_vld(ff_vld), .first_fail_idx(ff_idx),
    .first_fail_data(ff_data)
  );

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Stand-in core: known-answer for the FIPS-197 vector, a cheap mixing function otherwise.
  function automatic logic [127:0] cipher(input logic [127:0] p, input logic [127:0] k);
    if (p == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return {p[63:0] ^ k[127:64], p[127:64] + k[63:0]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  logic [DW-1:0] tb_pt [DEPTH];
  logic [DW-1:0] tb_key[DEPTH];
  logic [DW-1:0] tb_exp[DEPTH];

  bit            rsp_on = 1'b1;
  int            rsp_lat = 11;
  int            en_cnt = 0, unstable = 0, done_cnt = 0;
  int            run_len[$];
  logic [DW-1:0] run_pt[$];
  logic [DW-1:0] cur_pt, cur_key;

  always @(posedge clk) begin
    #1;
    rsp_valid = 1'b0;
    if (bus.aes_en) begin
      if (en_cnt == 0) begin
        cur_pt  = bus.aes_data_in;
        cur_key = bus.aes_key_in;
        run_pt.push_back(cur_pt);
      end else if (bus.aes_data_in !== cur_pt || bus.aes_key_in !== cur_key) begin
        unstable++;
      end
      en_cnt++;
      if (rsp_on && en_cnt == rsp_lat) begin
        rsp_valid = 1'b1;
        rsp_data  = cipher(cur_pt, cur_key);
      end
    end else if (en_cnt != 0) begin
      run_len.push_back(en_cnt);
      en_cnt = 0;
    end
  end

  always @(posedge clk) begin
    #2;
    if (done) done_cnt++;
  end

  int m_pass, m_fail, m_tmo, m_idx;
  bit m_vld;
  logic [DW-1:0] m_data;

  // Score the first min(n, DEPTH) slots from the table and the core's answer behaviour.
  function automatic void model(input int n);
    int eff = (n > DEPTH) ? DEPTH : n;
    logic [DW-1:0] r;
    m_pass = 0; m_fail = 0; m_tmo = 0; m_vld = 0; m_idx = 0; m_data = '0;
    for (int i = 0; i < eff; i++) begin
      if (rsp_on && rsp_lat <= TIMEOUT) begin
        r = cipher(tb_pt[i], tb_key[i]);
        if (r === tb_exp[i]) m_pass++;
        else begin
          m_fail++;
          if (!m_vld) begin m_vld = 1; m_idx = i; m_data = r; end
        end
      end else begin
        m_tmo++;
        m_fail++;
        if (!m_vld) begin m_vld = 1; m_idx = i; m_data = '0; end
      end
    end
  endfunction

  task automatic check_model(input string tag, input int spur);
    check({tag, ".pass"}, 128'(pass_cnt), 128'(m_pass));
    check({tag, ".fail"}, 128'(fail_cnt), 128'(m_fail));
    check({tag, ".tmo"}, 128'(timeout_cnt), 128'(m_tmo));
    check({tag, ".spur"}, 128'(spurious_cnt), 128'(spur));
    check({tag, ".ff_vld"}, 128'(ff_vld), 128'(m_vld));
    if (m_vld) begin
      check({tag, ".ff_idx"}, 128'(ff_idx), 128'(m_idx));
      check({tag, ".ff_data"}, ff_data, m_data);
    end
  endtask

  task automatic wr(input int slot, input int sel, input logic [DW-1:0] d);
    @(negedge clk);
    cfg_wr_en = 1'b1; cfg_wr_addr = AW'(slot); cfg_wr_sel = 2'(sel); cfg_wr_data = d;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic load(input int slot, input logic [DW-1:0] p, input logic [DW-1:0] k,
                      input logic [DW-1:0] e);
    tb_pt[slot] = p; tb_key[slot] = k; tb_exp[slot] = e;
    wr(slot, 0, p); wr(slot, 1, k); wr(slot, 2, e);
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic launch(input int n);
    run_len.delete(); run_pt.delete(); unstable = 0;
    @(negedge clk);
    cfg_num = (AW+1)'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int k = 0;
    while (!done && k < 20000) begin @(negedge clk); k++; end
    check({tag, ".done_seen"}, 128'(done), 128'(1));
    @(negedge clk);
    check({tag, ".done_1cyc"}, 128'(done), 128'(0));
    check({tag, ".busy_fall"}, 128'(busy), 128'(0));
    check({tag, ".stable"}, 128'(unstable), 128'(0));
  endtask

  initial begin
    logic [DW-1:0] p, k, e;
    int kk, d0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.busy", 128'(busy), 0);
    check("rst.done", 128'(done), 0);
    check("rst.en", 128'(bus.aes_en), 0);
    check("rst.din", bus.aes_data_in, 0);
    check("rst.cnts", 128'({pass_cnt, fail_cnt, timeout_cnt, spurious_cnt}), 0);
    check("rst.ff", 128'(ff_vld), 0);

    // FIPS-197 known answer, one vector.
    load(0, FIPS_PT, FIPS_KEY, FIPS_CT);
    rsp_on = 1; rsp_lat = 11;
    launch(1);
    check("fips.en", 128'(bus.aes_en), 1);
    check("fips.din", bus.aes_data_in, FIPS_PT);
    finish_run("fips");
    model(1); check_model("fips", 0);
    check("fips.hold_din", bus.aes_data_in, FIPS_PT);

    // Three random vectors, slot 1 expected value corrupted.
    for (int i = 0; i < 3; i++) begin
      p = rnd128(); k = rnd128(); e = cipher(p, k);
      if (i == 1) e[0] = ~e[0];
      load(i, p, k, e);
    end
    rsp_lat = $urandom_range(1, 20);
    launch(3); finish_run("three");
    model(3); check_model("three", 0);

    // Core never answers: every vector times out after exactly TIMEOUT enabled cycles.
    rsp_on = 0;
    launch(2); finish_run("tmo");
    model(2); check_model("tmo", 0);
    check("tmo.runs", 128'(run_len.size()), 2);
    foreach (run_len[i]) check("tmo.en_len", 128'(run_len[i]), TIMEOUT);

    // Empty run finishes right away.
    rsp_on = 1;
    launch(0);
    check("num0.done_now", 128'(done), 1);
    finish_run("num0");
    model(0); check_model("num0", 0);

    // Oversized count clamps to the full table; a write while busy must be dropped.
    for (int i = 0; i < DEPTH; i++) begin
      p = rnd128(); k = rnd128(); e = cipher(p, k);
      if ($urandom_range(0, 3) == 0) e[$urandom_range(0, 127)] ^= 1'b1;
      load(i, p, k, e);
    end
    rsp_lat = $urandom_range(1, 30);
    launch(15);
    wr(0, 2, ~tb_exp[0]);
    finish_run("num15");
    model(15); check_model("num15", 0);
    check("num15.runs", 128'(run_len.size()), DEPTH);
    foreach (run_pt[i]) if (i < DEPTH) check("num15.slot_pt", run_pt[i], tb_pt[i]);

    // Abort in the middle of vector 2.
    rsp_lat = 20;
    launch(4);
    kk = 0;
    while (!(run_len.size() == 1 && bus.aes_en) && kk < 1000) begin @(negedge clk); kk++; end
    check("abort.reached_v2", 128'(kk < 1000), 1);
    d0 = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort.en", 128'(bus.aes_en), 0);
    check("abort.busy", 128'(busy), 0);
    repeat (10) @(negedge clk);
    check("abort.no_done", 128'(done_cnt), 128'(d0));
    model(1); check_model("abort.kept", 0);
    launch(1);
    check("abort.clr_pass", 128'(pass_cnt), 0);
    check("abort.clr_fail", 128'(fail_cnt), 0);
    finish_run("abort.rerun");
    model(1); check_model("abort.rerun", 0);

    // Valid pulses outside RUN: one in GAP, one in IDLE.
    rsp_lat = 5;
    launch(2);
    kk = 0;
    while (!(run_len.size() == 1 && !bus.aes_en) && kk < 1000) begin @(negedge clk); kk++; end
    check("spur.reached_gap", 128'(busy && kk < 1000), 1);
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    finish_run("spur");
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    @(negedge clk);
    model(2); check_model("spur", 2);

    // Answer on the very last timeout cycle is compared, not timed out.
    rsp_lat = TIMEOUT;
    launch(1); finish_run("edge");
    model(1); check_model("edge", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
